// File: rtl/heap_pkg.sv
// heap_pkg: shared types and constants for the heap controller.
//   state_t          - controller FSM states (push path P_*, pop path Q_*)
//   OP_PUSH / OP_POP - encodings of the 'op' request input
package heap_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ERR,
    P_INIT,
    P_PAR,
    P_CMP,
    Q_TOP,
    Q_LAST,
    Q_LEFT,
    Q_RIGHT,
    Q_CMP,
    DONE
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/heap_better.sv
// heap_better: combinational strict key comparator.
//   a, b   in  DW  keys to compare
//   better out 1   a < b in min-heap mode, a > b in max-heap mode
// Equal keys are never "better", so equal keys never move in the heap.
module heap_better #(
  parameter int DW       = 8,
  parameter bit MAX_MODE = 1'b0
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          better
);

  generate
    if (MAX_MODE) begin : g_max
      assign better = (a > b);
    end else begin : g_min
      assign better = (a < b);
    end
  endgenerate

endmodule

// File: rtl/heap_ctrl.sv
// heap_ctrl: binary-heap controller for a heap stored in an external
// single-port RAM (1-based, address 0 unused, capacity 2^AW - 1).
//   clk, reset   clock / synchronous active-high reset
//   start, op    request strobe (IDLE only); op 0 = push din, 1 = pop root
//   din          key to push, held until done
//   dout         last popped key
//   busy         high outside IDLE
//   done, err    end-of-request pulse; err flags push-full / pop-empty
//   size         element count; full / empty derived from it
//   maddr, mdin, mwen, mdout   RAM port (mdout is an async read of maddr)
module heap_ctrl
  import heap_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter bit MAX_MODE = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] size,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mdin,
  output logic          mwen,
  input  logic [DW-1:0] mdout
);

  localparam logic [AW-1:0] CAP = '1;
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_reg;
  logic [AW-1:0] size_reg;
  logic [AW-1:0] idx_reg;
  logic [AW-1:0] cidx_reg;
  logic [DW-1:0] key_reg;
  logic [DW-1:0] child_reg;
  logic [DW-1:0] parent_reg;
  logic [DW-1:0] dout_reg;

  // Child indices on AW+1 bits so 2*idx cannot wrap past the last slot.
  logic [AW:0] lchild;
  logic [AW:0] rchild;
  logic [AW:0] size_ext;
  assign lchild   = {idx_reg, 1'b0};
  assign rchild   = {idx_reg, 1'b1};
  assign size_ext = {1'b0, size_reg};

  // Shared key-vs-neighbour compare: better(key, parent) on the way up,
  // better(child, key) on the way down.
  logic [DW-1:0] cmp_a;
  logic [DW-1:0] cmp_b;
  logic          key_better;
  logic          right_better;
  assign cmp_a = (state_reg == Q_CMP) ? child_reg : key_reg;
  assign cmp_b = (state_reg == Q_CMP) ? key_reg   : parent_reg;

  heap_better #(.DW(DW), .MAX_MODE(MAX_MODE)) u_key_cmp (
    .a      (cmp_a),
    .b      (cmp_b),
    .better (key_better)
  );

  // Right child (being read this cycle) against the latched left child.
  heap_better #(.DW(DW), .MAX_MODE(MAX_MODE)) u_child_cmp (
    .a      (mdout),
    .b      (child_reg),
    .better (right_better)
  );

  // RAM address / write mux. maddr rests on idx when nothing is read.
  always_comb begin
    maddr = idx_reg;
    mdin  = '0;
    mwen  = 1'b0;
    case (state_reg)
      P_PAR:   maddr = idx_reg >> 1;
      P_CMP: begin
        if (key_better) begin
          mwen = 1'b1;
          mdin = parent_reg;
        end
      end
      Q_TOP:   maddr = ONE;
      Q_LAST:  maddr = size_reg;
      Q_LEFT: begin
        if (lchild <= size_ext) maddr = lchild[AW-1:0];
      end
      Q_RIGHT: maddr = cidx_reg + ONE;
      Q_CMP: begin
        if (key_better) begin
          mwen = 1'b1;
          mdin = child_reg;
        end
      end
      DONE: begin
        mwen = 1'b1;
        mdin = key_reg;
      end
      default: ;
    endcase
    // A reset landing on a write cycle must not corrupt the RAM.
    if (reset) begin
      mwen = 1'b0;
      mdin = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      size_reg   <= '0;
      idx_reg    <= '0;
      cidx_reg   <= '0;
      key_reg    <= '0;
      child_reg  <= '0;
      parent_reg <= '0;
      dout_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (op == OP_PUSH) state_reg <= full  ? ERR : P_INIT;
            else               state_reg <= empty ? ERR : Q_TOP;
          end
        end
        ERR: state_reg <= IDLE;
        P_INIT: begin
          size_reg  <= size_reg + ONE;
          idx_reg   <= size_reg + ONE;
          key_reg   <= din;
          state_reg <= (size_reg == '0) ? DONE : P_PAR;
        end
        P_PAR: begin
          parent_reg <= mdout;
          state_reg  <= P_CMP;
        end
        P_CMP: begin
          if (key_better) begin
            idx_reg   <= idx_reg >> 1;
            state_reg <= ((idx_reg >> 1) == ONE) ? DONE : P_PAR;
          end else begin
            state_reg <= DONE;
          end
        end
        Q_TOP: begin
          dout_reg  <= mdout;
          state_reg <= Q_LAST;
        end
        Q_LAST: begin
          key_reg   <= mdout;
          size_reg  <= size_reg - ONE;
          idx_reg   <= ONE;
          state_reg <= Q_LEFT;
        end
        Q_LEFT: begin
          if (lchild > size_ext) begin
            state_reg <= DONE;
          end else begin
            child_reg <= mdout;
            cidx_reg  <= lchild[AW-1:0];
            state_reg <= (rchild <= size_ext) ? Q_RIGHT : Q_CMP;
          end
        end
        Q_RIGHT: begin
          if (right_better) begin
            child_reg <= mdout;
            cidx_reg  <= cidx_reg + ONE;
          end
          state_reg <= Q_CMP;
        end
        Q_CMP: begin
          if (key_better) begin
            idx_reg   <= cidx_reg;
            state_reg <= Q_LEFT;
          end else begin
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dout  = dout_reg;
  assign size  = size_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE) || (state_reg == ERR);
  assign err   = (state_reg == ERR);
  assign full  = (size_reg == CAP);
  assign empty = (size_reg == '0);

endmodule

// File: tb/tb_heap_ctrl.sv
// tb_heap_ctrl: directed bench for heap_ctrl. Three instances:
//   0: min-heap AW=8, 1: min-heap AW=2 (CAP=3), 2: max-heap AW=8,
// each with its own asynchronous-read RAM model.
module tb_heap_ctrl;
  import heap_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start_v [3];
  logic       op_v    [3];
  logic [7:0] din_v   [3];

  wire [7:0] dout_w  [3];
  wire [7:0] size_w  [3];
  wire [7:0] maddr_w [3];
  wire [7:0] mdin_w  [3];
  wire [7:0] mdout_w [3];
  wire       busy_w  [3];
  wire       done_w  [3];
  wire       err_w   [3];
  wire       full_w  [3];
  wire       empty_w [3];
  wire       mwen_w  [3];
  wire [1:0] size1;
  wire [1:0] maddr1;

  logic [7:0] ram0 [256];
  logic [7:0] ram1 [4];
  logic [7:0] ram2 [256];

  assign size_w[1]  = {6'd0, size1};
  assign maddr_w[1] = {6'd0, maddr1};
  assign mdout_w[0] = ram0[maddr_w[0]];
  assign mdout_w[1] = ram1[maddr1];
  assign mdout_w[2] = ram2[maddr_w[2]];

  always @(posedge clk) begin
    if (mwen_w[0]) ram0[maddr_w[0]] <= mdin_w[0];
    if (mwen_w[1]) ram1[maddr1]     <= mdin_w[1];
    if (mwen_w[2]) ram2[maddr_w[2]] <= mdin_w[2];
  end

  heap_ctrl #(.DW(8), .AW(8), .MAX_MODE(1'b0)) u_min (
    .clk(clk), .reset(reset), .start(start_v[0]), .op(op_v[0]), .din(din_v[0]),
    .dout(dout_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
    .size(size_w[0]), .full(full_w[0]), .empty(empty_w[0]),
    .maddr(maddr_w[0]), .mdin(mdin_w[0]), .mwen(mwen_w[0]), .mdout(mdout_w[0])
  );

  heap_ctrl #(.DW(8), .AW(2), .MAX_MODE(1'b0)) u_small (
    .clk(clk), .reset(reset), .start(start_v[1]), .op(op_v[1]), .din(din_v[1]),
    .dout(dout_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
    .size(size1), .full(full_w[1]), .empty(empty_w[1]),
    .maddr(maddr1), .mdin(mdin_w[1]), .mwen(mwen_w[1]), .mdout(mdout_w[1])
  );

  heap_ctrl #(.DW(8), .AW(8), .MAX_MODE(1'b1)) u_max (
    .clk(clk), .reset(reset), .start(start_v[2]), .op(op_v[2]), .din(din_v[2]),
    .dout(dout_w[2]), .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2]),
    .size(size_w[2]), .full(full_w[2]), .empty(empty_w[2]),
    .maddr(maddr_w[2]), .mdin(mdin_w[2]), .mwen(mwen_w[2]), .mdout(mdout_w[2])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Results of the most recent run_op.
  int r_cyc, r_err, r_nwr, r_dout, r_size, r_full, r_empty;
  int wa [8];
  int wd [8];

  // Issue one request and follow it to done, logging every RAM write.
  task automatic run_op(input int u, input logic o, input logic [7:0] k);
    bit got_done;
    @(negedge clk);
    start_v[u] = 1'b1;
    op_v[u]    = o;
    din_v[u]   = k;
    @(negedge clk);
    start_v[u] = 1'b0;
    r_cyc = 0; r_nwr = 0; r_err = 0; got_done = 1'b0;
    while (r_cyc < 64 && !got_done) begin
      r_cyc++;
      if (mwen_w[u]) begin
        if (r_nwr < 8) begin
          wa[r_nwr] = maddr_w[u];
          wd[r_nwr] = mdin_w[u];
        end
        r_nwr++;
      end
      if (done_w[u]) begin
        got_done = 1'b1;
        r_err    = err_w[u];
        r_dout   = dout_w[u];
        r_size   = size_w[u];
        r_full   = full_w[u];
        r_empty  = empty_w[u];
      end else begin
        @(negedge clk);
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    $display("op dut%0d %s key=%0d cycles=%0d err=%0d writes=%0d size=%0d dout=%0d",
             u, (o == OP_PUSH) ? "push" : "pop ", k, r_cyc, r_err, r_nwr, r_size, r_dout);
  endtask

  initial begin
    int exp_pop [4];
    int ndone;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      op_v[i]    = 1'b0;
      din_v[i]   = 8'd0;
    end

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_size",  size_w[0], 0);
    check("rst_empty", empty_w[0], 1);
    check("rst_busy",  busy_w[0], 0);
    check("rst_done",  done_w[0], 0);
    check("rst_mwen",  mwen_w[0], 0);
    check("rst_maddr", maddr_w[0], 0);
    check("rst_mdin",  mdin_w[0], 0);
    check("rst_dout",  dout_w[0], 0);

    // Push into empty heap: 2 cycles, one write 5@1
    run_op(0, OP_PUSH, 8'd5);
    check("p5_cyc", r_cyc, 2);
    check("p5_nwr", r_nwr, 1);
    check("p5_addr", wa[0], 1);
    check("p5_data", wd[0], 5);
    check("p5_size", r_size, 1);
    check("p5_err", r_err, 0);
    run_op(0, OP_POP, 8'd0);
    check("q5_dout", r_dout, 5);
    check("q5_cyc", r_cyc, 4);
    check("q5_empty", r_empty, 1);

    // Min-heap pushes 7,3,9,1
    run_op(0, OP_PUSH, 8'd7);
    run_op(0, OP_PUSH, 8'd3);
    check("p3_cyc", r_cyc, 4);
    run_op(0, OP_PUSH, 8'd9);
    run_op(0, OP_PUSH, 8'd1);
    check("p1_cyc", r_cyc, 6);
    check("p1_nwr", r_nwr, 3);
    check("p1_wa0", wa[0], 4); check("p1_wd0", wd[0], 7);
    check("p1_wa1", wa[1], 2); check("p1_wd1", wd[1], 3);
    check("p1_wa2", wa[2], 1); check("p1_wd2", wd[2], 1);
    check("p1_size", r_size, 4);
    @(negedge clk);
    check("ram0_1", ram0[1], 1);
    check("ram0_2", ram0[2], 3);
    check("ram0_3", ram0[3], 9);
    check("ram0_4", ram0[4], 7);

    // Pops in ascending order
    exp_pop = '{1, 3, 7, 9};
    for (int i = 0; i < 4; i++) begin
      run_op(0, OP_POP, 8'd0);
      check($sformatf("pop%0d_dout", i), r_dout, exp_pop[i]);
      check($sformatf("pop%0d_size", i), r_size, 3 - i);
      if (i == 0) check("pop0_cyc", r_cyc, 7);
    end
    check("pop_empty", r_empty, 1);

    // Pop when empty
    run_op(0, OP_POP, 8'd0);
    check("qe_err", r_err, 1);
    check("qe_cyc", r_cyc, 1);
    check("qe_nwr", r_nwr, 0);
    check("qe_size", r_size, 0);

    // AW=2: equal keys, full, push-when-full
    run_op(1, OP_PUSH, 8'd4);
    run_op(1, OP_PUSH, 8'd4);
    check("eq_nwr", r_nwr, 1);
    check("eq_addr", wa[0], 2);
    check("eq_cyc", r_cyc, 4);
    run_op(1, OP_PUSH, 8'd6);
    check("sm_full", r_full, 1);
    check("sm_size", r_size, 3);
    run_op(1, OP_PUSH, 8'd1);
    check("pf_err", r_err, 1);
    check("pf_nwr", r_nwr, 0);
    check("pf_size", r_size, 3);
    @(negedge clk);
    check("ram1_1", ram1[1], 4);
    check("ram1_2", ram1[2], 4);
    check("ram1_3", ram1[3], 6);

    // Max-heap: push 2,8,5 then pop 8,5,2
    run_op(2, OP_PUSH, 8'd2);
    run_op(2, OP_PUSH, 8'd8);
    run_op(2, OP_PUSH, 8'd5);
    exp_pop = '{8, 5, 2, 0};
    for (int i = 0; i < 3; i++) begin
      run_op(2, OP_POP, 8'd0);
      check($sformatf("max%0d_dout", i), r_dout, exp_pop[i]);
    end
    check("max_empty", r_empty, 1);

    // Reset during P_CMP of a swapping push
    run_op(0, OP_PUSH, 8'd4);
    @(negedge clk);
    start_v[0] = 1'b1; op_v[0] = OP_PUSH; din_v[0] = 8'd2;
    @(negedge clk);
    start_v[0] = 1'b0;          // P_INIT
    @(negedge clk);             // P_PAR
    @(negedge clk);             // P_CMP
    check("pcmp_mwen", mwen_w[0], 1);
    check("pcmp_maddr", maddr_w[0], 2);
    check("pcmp_mdin", mdin_w[0], 4);
    reset = 1'b1;
    #1;
    check("rstw_mwen", mwen_w[0], 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstw_busy", busy_w[0], 0);
    check("rstw_size", size_w[0], 0);
    check("rstw_mwen2", mwen_w[0], 0);
    check("rstw_ram2", ram0[2], 9);
    check("rstw_ram1", ram0[1], 4);

    // start held while busy is ignored
    run_op(0, OP_PUSH, 8'd6);
    check("h6_cyc", r_cyc, 2);
    @(negedge clk);
    start_v[0] = 1'b1; op_v[0] = OP_PUSH; din_v[0] = 8'd3;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_w[0]) begin
        ndone++;
        start_v[0] = 1'b0;
      end
    end
    start_v[0] = 1'b0;
    $display("op dut0 held-start push key=3 dones=%0d size=%0d", ndone, size_w[0]);
    check("hold_ndone", ndone, 1);
    check("hold_size", size_w[0], 2);
    check("hold_ram1", ram0[1], 3);
    check("hold_ram2", ram0[2], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
